// File: rtl/display_mux_pwm.sv
// Multiplexed seven-segment driver: scans NUM_DIGITS digits of one of NUM_PAGES pages onto
// active-low anode/cathode pins, with frame-aligned page switching, blink, PWM dimming and ghost blanking.
module display_mux_pwm #(
    parameter  int NUM_DIGITS   = 4,
    parameter  int NUM_PAGES    = 2,
    parameter  int SEG_W        = 7,
    parameter  int REFRESH_DIV  = 100000,
    parameter  int BLINK_FRAMES = 128,
    parameter  int BRIGHT_W     = 3,
    localparam int PAGE_W       = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [PAGE_W-1:0]                   page_sel,
    input  logic [NUM_PAGES*NUM_DIGITS*SEG_W-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]               blink_mask,
    input  logic [BRIGHT_W-1:0]                 brightness,
    output logic [NUM_DIGITS-1:0]               anode,
    output logic [SEG_W-1:0]                    display_ssd,
    output logic                                frame_tick
);

    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int SEL_W   = (NUM_PAGES * NUM_DIGITS > 1) ? $clog2(NUM_PAGES * NUM_DIGITS) : 1;

    localparam logic [PRESC_W-1:0]    PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [DIG_W-1:0]      DIG_MAX   = DIG_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0]      FRM_MAX   = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [PAGE_W-1:0]     PAGE_MAX  = PAGE_W'(NUM_PAGES - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE   = NUM_DIGITS'(1);

    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [DIG_W-1:0]      digit_q, digit_d;
    logic [PAGE_W-1:0]     page_q, page_d;
    logic [BRIGHT_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [FRM_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [SEG_W-1:0]      ssd_q, ssd_d;
    logic                  frame_tick_q, frame_tick_d;

    logic [NUM_PAGES*NUM_DIGITS-1:0][SEG_W-1:0] seg_arr;
    logic [SEL_W-1:0] sel_idx;
    int               sel_int;
    logic             frame_wrap;
    logic             visible;

    assign seg_arr = seg_in;

    always_comb begin
        presc_d       = presc_q + 1'b1;
        digit_d       = digit_q;
        page_d        = page_q;
        pwm_cnt_d     = pwm_cnt_q + 1'b1;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        frame_wrap    = 1'b0;

        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (digit_q == DIG_MAX) begin
                digit_d    = '0;
                frame_wrap = 1'b1;
            end else begin
                digit_d = digit_q + 1'b1;
            end
        end

        // Page and blink state only move at a frame boundary so a frame never mixes pages.
        if (frame_wrap) begin
            if (page_sel <= PAGE_MAX) begin
                page_d = page_sel;
            end
            if (frame_cnt_q == FRM_MAX) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        sel_int = int'(page_q) * NUM_DIGITS + int'(digit_q);
        sel_idx = sel_int[SEL_W-1:0];

        // presc == 0 is the ghost guard cycle at every digit change.
        visible = (presc_q != '0) && (pwm_cnt_q <= brightness) &&
                  !(blink_phase_q && blink_mask[digit_q]);

        anode_d      = visible ? ~(DIG_ONE << digit_q) : '1;
        ssd_d        = visible ? ~seg_arr[sel_idx] : '1;
        frame_tick_d = frame_wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q       <= '0;
            digit_q       <= '0;
            page_q        <= '0;
            pwm_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            anode_q       <= '1;
            ssd_q         <= '1;
            frame_tick_q  <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            digit_q       <= digit_d;
            page_q        <= page_d;
            pwm_cnt_q     <= pwm_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            anode_q       <= anode_d;
            ssd_q         <= ssd_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign anode       = anode_q;
    assign display_ssd = ssd_q;
    assign frame_tick  = frame_tick_q;

endmodule
